ysyx_23060203_ifu_fetch: RTL and testbench
==========================================

Name: ysyx_23060203_ifu_fetch

Overview:
Instruction fetch stage that sits directly upstream of the decode stage. It generates the fetch PC, issues one-at-a-time requests on a simple valid/ready instruction-memory port, and buffers the returned instruction. It applies static backward-taken/forward-not-taken (BTFN) prediction for conditional branches and redirects on decode mispredict (jump_flush) or back-end flush.

Parameters:
RESET_PC, 32'h3000_0000, PC fetched first after reset

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high
flush  in  1  back-end flush (exception, mret, fence.i); highest priority redirect
flush_pc  in  32  target PC when flush=1
jump_flush  in  1  decode mispredict redirect
jump_dnpc  in  32  target PC when jump_flush=1
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address, word-aligned
imem_resp_valid  in  1  response valid
imem_resp_ready  out  1  fetch stage accepts response
imem_resp_data  in  32  instruction word
out_valid  out  1  buffered instruction valid to decode
out_ready  in  1  decode in_ready
out_pc  out  32  PC of buffered instruction
out_inst  out  32  buffered instruction

Behaviour:
- Reset: fetch_pc=RESET_PC; state=S_REQ; buf_valid=0; drop=0. Output values on reset: imem_req_valid=1 in the first cycle after reset deasserts, out_valid=0, imem_resp_ready=0.
- Redirect: redir = flush | jump_flush. Target is flush_pc if flush=1, else jump_dnpc; flush has priority. On redir: fetch_pc<=target; buf_valid<=0. If a request is outstanding or in S_REQ but not yet accepted, drop<=1.
- FSM:
  - S_REQ:
    - imem_req_valid=1, addr=fetch_pc. Address and valid stay stable until imem_req_ready, even across a redirect.
    - On accept: go to S_WAIT and latch req_pc=fetch_pc. A redirect in the same cycle sets drop=1.
  - S_WAIT:
    - imem_resp_ready = drop | ~buf_valid | (out_valid & out_ready).
    - On response with drop=1: discard it, drop<=0, go to S_REQ. The fetch_pc used is the redirected one.
    - On response with drop=0 and no redirect this cycle: buf<={req_pc, data}, buf_valid<=1, fetch_pc<=npc, go to S_REQ.
    - On response with drop=0 and a redirect in the same cycle: discard the response; fetch_pc<=target.
- Prediction (npc): if data[6:2]==5'b11000 (BRANCH) and data[31]==1, npc=req_pc+imm_b, where imm_b={{20{d[31]}},d[7],d[30:25],d[11:8],1'b0}. Otherwise npc=req_pc+4. JAL/JALR are not predicted; they fall through and decode always redirects them. 32-bit adds wrap modulo 2^32.
- Output: out_valid = buf_valid & ~flush & ~jump_flush, so no handshake fires in a redirect cycle. out_pc/out_inst are held stable while out_valid & ~out_ready. buf_valid clears on out handshake unless refilled in the same cycle.
- At most one outstanding request. Prefetch of the next request is allowed while the buffer is full; back-pressure is applied via imem_resp_ready.
- Repeated jump_flush over several cycles with the same jump_dnpc is idempotent: the same target is reloaded each cycle, and drop stays set only for a single in-flight response.
- Reset mid-transaction: state returns to S_REQ with drop=0. The memory side is reset concurrently; no response is expected after reset.

Test Plan:
1. Straight line: reset, memory responds in 1 cycle with NOPs (0x00000013), out_ready=1 → out_pc sequence 0x30000000, 0x30000004, 0x30000008; no bubbles beyond the memory latency.
2. Backward branch 0xFE000EE3 (beq x0,x0,-4) at 0x30000008 → next imem_req_addr=0x30000004. Forward branch 0x00000463 at 0x30000008 → next addr 0x3000000C.
3. jump_flush=1 with jump_dnpc=0x30000100 while a request is in S_WAIT → that response is discarded (out_valid stays 0), next request addr=0x30000100, and the first out_pc is 0x30000100.
4. flush=1 (flush_pc=0x30000200) and jump_flush=1 (dnpc=0x30000100) in the same cycle → next fetch addr=0x30000200.
5. out_ready=0 for 5 cycles with buffer full and next response pending → imem_resp_ready=0, out_pc/out_inst stable. On out_ready=1 the buffer drains and refills in the same cycle.
6. imem_req_ready held 0 for 3 cycles, then jump_flush pulses → req_addr unchanged until accept, the response is dropped, and the following request goes to jump_dnpc.

Source files
------------

// File: rtl/ysyx_23060203_ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, a one-entry instruction buffer
// towards decode, static BTFN prediction and flush / jump_flush redirects.
module ysyx_23060203_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        jump_flush,
    input  logic [31:0] jump_dnpc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    output logic        imem_resp_ready,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);
    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc, req_pc, buf_pc, buf_inst;
    logic        buf_valid, drop;
    logic        redir, taken, resp_fire, out_fire, fill;
    logic [31:0] redir_pc, imm_b, npc;

    assign redir    = flush | jump_flush;
    assign redir_pc = flush ? flush_pc : jump_dnpc;

    // Backward conditional branches are predicted taken, everything else falls through.
    assign imm_b = {{20{imem_resp_data[31]}}, imem_resp_data[7], imem_resp_data[30:25],
                    imem_resp_data[11:8], 1'b0};
    assign taken = (imem_resp_data[6:2] == 5'b11000) & imem_resp_data[31];
    assign npc   = req_pc + (taken ? imm_b : 32'd4);

    assign out_valid = buf_valid & ~redir;
    assign out_pc    = buf_pc;
    assign out_inst  = buf_inst;
    assign out_fire  = out_valid & out_ready;

    // req_pc doubles as the presented address so it stays put across redirects until accepted.
    assign imem_req_addr = req_pc;
    assign resp_fire     = imem_resp_valid & imem_resp_ready;
    assign fill          = resp_fire & ~drop & ~redir;

    always_comb begin
        state_next      = state;
        imem_req_valid  = 1'b0;
        imem_resp_ready = 1'b0;
        case (state)
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                imem_resp_ready = drop | ~buf_valid | out_fire;
                if (imem_resp_valid & imem_resp_ready) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_REQ;
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            buf_valid <= 1'b0;
            buf_pc    <= 32'd0;
            buf_inst  <= 32'd0;
            drop      <= 1'b0;
        end else begin
            state <= state_next;

            if (redir)     fetch_pc <= redir_pc;
            else if (fill) fetch_pc <= npc;

            // The next request address is chosen when the current response retires.
            if (resp_fire) req_pc <= redir ? redir_pc : (drop ? fetch_pc : npc);

            // Any redirect poisons the in-flight or not-yet-accepted request.
            if (resp_fire)  drop <= 1'b0;
            else if (redir) drop <= 1'b1;

            if (fill) begin
                buf_valid <= 1'b1;
                buf_pc    <= req_pc;
                buf_inst  <= imem_resp_data;
            end else if (redir | out_fire) begin
                buf_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060203_ifu_fetch.sv
// Bench for the fetch stage: a latency-randomised memory plus a program-order stream model
// of which (pc, inst) pairs decode must receive.
module tb_ysyx_23060203_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset, flush, jump_flush, imem_req_valid, imem_req_ready;
    logic        imem_resp_valid, imem_resp_ready, out_valid, out_ready;
    logic [31:0] flush_pc, jump_dnpc, imem_req_addr, imem_resp_data, out_pc, out_inst;

    always #5 clock = ~clock;

    ysyx_23060203_ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_ready(imem_resp_ready), .imem_resp_data(imem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
    );

    int checks = 0, failures = 0;
    int p_out_ready, p_req_ready, p_redir, min_lat, max_lat, jf_hold, delivered;
    bit directed, just_reset;
    logic [31:0] dir_inst, dir_off;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_lat;
    logic [31:0] exp_pc;
    logic [31:0] got_pc[$];
    logic [31:0] acc_addr[$];
    logic        prev_out_hold, prev_req_hold;
    logic [31:0] prev_out_pc, prev_out_inst, prev_req_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] enc_branch(input int imm);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], 10'd0, 3'b000, i[4:1], i[11], 7'b1100011};
    endfunction

    // Program image: instruction at addr and the distance to the predicted next fetch.
    function automatic void prog(input logic [31:0] addr, output logic [31:0] inst,
                                 output logic [31:0] off);
        logic [31:0] h;
        int k;
        inst = NOP;
        off  = 32'd4;
        if (directed) begin
            if (addr == 32'h3000_0008) begin
                inst = dir_inst;
                off  = dir_off;
            end
        end else begin
            h = (addr >> 2) * 32'h9E37_79B1;
            h = h ^ (h >> 15);
            k = 1 + int'((h >> 8) % 6);
            case (h % 10)
                6, 7: begin inst = enc_branch(-4 * k); off = 32'(-4 * k); end
                8:    inst = enc_branch(4 * k);
                9:    inst = 32'hFE00_006F;
                default: inst = NOP;
            endcase
        end
    endfunction

    function automatic logic [31:0] rand_target();
        return RESET_PC + 32'($urandom_range(255)) * 32'd4;
    endfunction

    task automatic applyStimulus();
        logic [31:0] d, o;
        @(negedge clock);
        reset = 1'b0;
        imem_resp_valid = mem_busy && (mem_lat == 0);
        if (mem_busy) begin
            prog(mem_addr, d, o);
            imem_resp_data = d;
        end else begin
            imem_resp_data = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < p_req_ready);
        out_ready      = ($urandom_range(99) < p_out_ready);
        if (jf_hold > 0) begin
            jump_flush = 1'b1;
            jf_hold--;
        end else if ($urandom_range(99) < p_redir) begin
            jump_flush = 1'b1;
            jump_dnpc  = rand_target();
            jf_hold    = $urandom_range(2);
        end else begin
            jump_flush = 1'b0;
        end
        flush    = ($urandom_range(199) < p_redir);
        flush_pc = rand_target();
    endtask

    task automatic checkOutput();
        logic        redir;
        logic [31:0] tgt, inst, off;
        #1;
        redir = flush | jump_flush;
        tgt   = flush ? flush_pc : jump_dnpc;
        if (just_reset) begin
            check("reset_req_valid", 32'(imem_req_valid), 32'd1);
            check("reset_req_addr", imem_req_addr, RESET_PC);
            check("reset_out_valid", 32'(out_valid), 32'd0);
            check("reset_resp_ready", 32'(imem_resp_ready), 32'd0);
            just_reset = 1'b0;
        end
        if (prev_req_hold) begin
            check("req_valid_held", 32'(imem_req_valid), 32'd1);
            check("req_addr_held", imem_req_addr, prev_req_addr);
        end
        if (prev_out_hold && out_valid) begin
            check("out_pc_held", out_pc, prev_out_pc);
            check("out_inst_held", out_inst, prev_out_inst);
        end
        if (imem_req_valid) check("one_outstanding", 32'(mem_busy), 32'd0);
        if (imem_resp_valid && out_valid)
            check("resp_backpressure", 32'(imem_resp_ready), 32'(out_ready));
        if (redir) begin
            check("no_out_on_redir", 32'(out_valid), 32'd0);
            exp_pc = tgt;
        end else if (out_valid && out_ready) begin
            prog(exp_pc, inst, off);
            check("out_pc", out_pc, exp_pc);
            check("out_inst", out_inst, inst);
            got_pc.push_back(out_pc);
            delivered++;
            exp_pc = exp_pc + off;
        end
        if (imem_resp_valid && imem_resp_ready) mem_busy = 1'b0;
        else if (mem_busy && mem_lat > 0) mem_lat--;
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
            acc_addr.push_back(imem_req_addr);
            mem_busy = 1'b1;
            mem_addr = imem_req_addr;
            mem_lat  = $urandom_range(min_lat, max_lat);
        end
        prev_req_hold = imem_req_valid && !imem_req_ready;
        prev_req_addr = imem_req_addr;
        prev_out_hold = out_valid && !out_ready;
        prev_out_pc   = out_pc;
        prev_out_inst = out_inst;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1; flush = 1'b0; jump_flush = 1'b0; out_ready = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        flush_pc = 32'd0; jump_dnpc = 32'd0;
        repeat (2) @(posedge clock);
        mem_busy = 1'b0; mem_lat = 0; mem_addr = 32'd0; exp_pc = RESET_PC; jf_hold = 0;
        prev_req_hold = 1'b0; prev_out_hold = 1'b0; just_reset = 1'b1;
        got_pc.delete();
        acc_addr.delete();
    endtask

    task automatic step();
        applyStimulus();
        checkOutput();
    endtask

    task automatic runUntil(input int n, input int limit, input string name);
        for (int i = 0; i < limit && got_pc.size() < n; i++) step();
        check(name, 32'(got_pc.size() >= n), 32'd1);
    endtask

    task automatic setDirected(input int lat, input int pout, input int preq);
        directed = 1'b1; p_redir = 0; min_lat = lat; max_lat = lat;
        p_out_ready = pout; p_req_ready = preq;
    endtask

    initial begin
        check("enc_backward", enc_branch(-4), 32'hFE00_0EE3);
        check("enc_forward", enc_branch(8), 32'h0000_0463);

        // Straight line then backward branch at 0x30000008.
        setDirected(0, 100, 100);
        dir_inst = 32'hFE00_0EE3; dir_off = 32'hFFFF_FFFC;
        doReset();
        runUntil(5, 12, "straight_line_progress");
        check("seq0", got_pc[0], 32'h3000_0000);
        check("seq1", got_pc[1], 32'h3000_0004);
        check("seq2", got_pc[2], 32'h3000_0008);
        check("seq_backward", got_pc[3], 32'h3000_0004);

        // Forward branch falls through.
        dir_inst = 32'h0000_0463; dir_off = 32'd4;
        doReset();
        runUntil(4, 20, "forward_progress");
        check("seq_forward", got_pc[3], 32'h3000_000C);

        // jump_flush while the first request is in flight.
        dir_inst = NOP;
        setDirected(3, 100, 100);
        doReset();
        for (int i = 0; i < 10 && !mem_busy; i++) step();
        acc_addr.delete();
        applyStimulus();
        jump_flush = 1'b1; jump_dnpc = 32'h3000_0100;
        checkOutput();
        runUntil(1, 30, "jump_wait_progress");
        check("jump_wait_req", acc_addr[0], 32'h3000_0100);
        check("jump_wait_out", got_pc[0], 32'h3000_0100);

        // flush wins over a simultaneous jump_flush.
        setDirected(1, 100, 100);
        doReset();
        repeat (5) step();
        applyStimulus();
        flush = 1'b1; flush_pc = 32'h3000_0200; jump_flush = 1'b1; jump_dnpc = 32'h3000_0100;
        checkOutput();
        got_pc.delete();
        runUntil(1, 30, "flush_prio_progress");
        check("flush_priority", got_pc[0], 32'h3000_0200);

        // Output back-pressure with a response pending, then drain and refill together.
        setDirected(0, 0, 100);
        doReset();
        repeat (8) step();
        check("bp_resp_valid", 32'(imem_resp_valid), 32'd1);
        check("bp_resp_ready", 32'(imem_resp_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        p_out_ready = 100;
        step();
        check("drain_refill", 32'(imem_resp_ready), 32'd1);
        runUntil(2, 20, "bp_progress");
        check("bp_seq1", got_pc[1], 32'h3000_0004);

        // Request stalled by imem_req_ready, then redirected before accept.
        setDirected(1, 100, 0);
        doReset();
        repeat (3) step();
        applyStimulus();
        jump_flush = 1'b1; jump_dnpc = 32'h3000_0100;
        checkOutput();
        p_req_ready = 100;
        runUntil(1, 30, "stall_progress");
        check("stall_first_req", acc_addr[0], RESET_PC);
        check("stall_second_req", acc_addr[1], 32'h3000_0100);
        check("stall_out", got_pc[0], 32'h3000_0100);

        // Randomised run with a reset in the middle.
        directed = 1'b0; p_out_ready = 70; p_req_ready = 60; p_redir = 4;
        min_lat = 0; max_lat = 3;
        doReset();
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset();
            step();
        end
        check("random_progress", 32'(delivered > 200), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
